// File: rtl/scan_chain_driver_pkg.sv
// Shared scan-chain constants: chain length derived from the memory_bank
// geometry, plus the driver state encoding.
package scan_chain_driver_pkg;

    localparam int MEM_SIZE          = 32;
    localparam int DATA_WIDTH        = 8;
    localparam int EXTRA_SCAN_BITS   = 0;
    localparam int CHAIN_LEN_DEFAULT = MEM_SIZE * DATA_WIDTH + EXTRA_SCAN_BITS;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        EMIT  = 3'd3,
        DONE  = 3'd4
    } scan_state_t;

    function automatic bit chain_len_ok(input int n);
        return (n > 0) && (n % 8 == 0);
    endfunction

endpackage

// File: rtl/scan_chain_driver.sv
// Scan-chain initiator: serialises host bytes into the chain head while
// capturing the tail bits back into bytes, one byte in flight at a time.
module scan_chain_driver
    import scan_chain_driver_pkg::*;
#(
    parameter int CHAIN_LEN = CHAIN_LEN_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       scan_enable,
    output logic       scan_in,
    input  logic       scan_out,
    output logic       busy,
    output logic       done
);

    localparam int NBYTES = CHAIN_LEN / 8;
    localparam int BCW    = $clog2(NBYTES + 1);

    if (!chain_len_ok(CHAIN_LEN)) begin : g_bad_len
        $error("CHAIN_LEN must be a nonzero multiple of 8");
    end

    scan_state_t    state, state_d;
    logic [7:0]     shreg, shreg_d;
    logic [BCW-1:0] byte_cnt, byte_cnt_d;
    logic [2:0]     bit_cnt, bit_cnt_d;
    logic           busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            byte_cnt <= '0;
            bit_cnt  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_d;
            shreg    <= shreg_d;
            byte_cnt <= byte_cnt_d;
            bit_cnt  <= bit_cnt_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d    = state;
        shreg_d    = shreg;
        byte_cnt_d = byte_cnt;
        bit_cnt_d  = bit_cnt;
        busy_d     = busy_q;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    byte_cnt_d = BCW'(NBYTES);
                    busy_d     = 1'b1;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    shreg_d   = in_data;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // Tail bit is captured at the same edge that shifts the chain.
                shreg_d = {scan_out, shreg[7:1]};
                if (bit_cnt == 3'd7) begin
                    state_d = EMIT;
                end else begin
                    bit_cnt_d = bit_cnt + 3'd1;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    byte_cnt_d = byte_cnt - BCW'(1);
                    state_d    = (byte_cnt_d == '0) ? DONE : LOAD;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Only SHIFT moves the chain, so any stall leaves it frozen.
    assign in_ready    = (state == LOAD);
    assign out_valid   = (state == EMIT);
    assign scan_enable = (state == SHIFT);
    assign done        = (state == DONE);
    assign out_data    = shreg;
    assign scan_in     = shreg[0];
    assign busy        = busy_q;

endmodule

// File: tb/tb_scan_chain_driver.sv
// Bench for scan_chain_driver: 256-bit chain model plus an 8-bit loopback
// instance; readback is scored against the previous pass's input bytes.
module tb_scan_chain_driver;

    localparam int NB = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, out_valid, scan_enable, scan_in, scan_out, busy, done;
    logic [7:0] out_data;

    logic       start8 = 1'b0;
    logic [7:0] in_data8 = '0;
    logic       in_valid8 = 1'b0;
    logic       out_ready8 = 1'b0;
    logic       in_ready8, out_valid8, scan_enable8, scan_in8, scan_out8;
    logic       busy8, done8;
    logic [7:0] out_data8;

    scan_chain_driver #(.CHAIN_LEN(256)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .scan_enable(scan_enable), .scan_in(scan_in), .scan_out(scan_out),
        .busy(busy), .done(done)
    );

    scan_chain_driver #(.CHAIN_LEN(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8),
        .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
        .out_data(out_data8), .out_valid(out_valid8), .out_ready(out_ready8),
        .scan_enable(scan_enable8), .scan_in(scan_in8), .scan_out(scan_out8),
        .busy(busy8), .done(done8)
    );

    // Chain models: index 0 is the tail.
    logic [255:0] chain = '0;
    logic [7:0]   loop8 = '0;
    assign scan_out  = chain[0];
    assign scan_out8 = loop8[0];

    int se_cnt = 0, done_cnt = 0, busy8_cnt = 0, overlap_cnt = 0;

    always @(posedge clk) begin
        if (!rst && scan_enable === 1'b1) chain <= {scan_in, chain[255:1]};
        if (!rst && scan_enable8 === 1'b1) loop8 <= {scan_in8, loop8[7:1]};
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (scan_enable === 1'b1) se_cnt++;
            if (done === 1'b1) done_cnt++;
            if (busy8 === 1'b1) busy8_cnt++;
            if (in_ready === 1'b1 && out_valid === 1'b1) overlap_cnt++;
        end
    end

    int n_cmp = 0, n_bad = 0;
    logic [7:0] wr_buf [NB];
    logic [7:0] prev_buf [NB];
    logic [7:0] exp_q [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_pass(input int gap_max, input int stall_at,
                            input int busy_start_at, input bit start_in_done);
        int se0, d0, t, lat, g, stall_bad;
        logic [7:0] hold, e;
        logic [255:0] snap;
        se0 = se_cnt;
        d0  = done_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        for (int k = 0; k < NB; k++) begin
            if (gap_max > 0) begin
                g = $urandom_range(0, gap_max);
                repeat (g) step();
            end
            t = 0;
            while (!in_ready && t < 40) begin step(); t++; end
            chk("in_ready_wait", in_ready, 1);
            in_data  = wr_buf[k];
            in_valid = 1'b1;
            exp_q.push_back(prev_buf[k]);
            step();
            in_valid = 1'b0;
            in_data  = '0;
            lat = 0;
            while (!out_valid && lat < 40) begin
                start = (k == busy_start_at && lat == 2);
                step();
                lat++;
            end
            start = 1'b0;
            chk($sformatf("lat%0d", k), lat, 8);
            if (k == stall_at) begin
                hold = out_data;
                snap = chain;
                stall_bad = 0;
                repeat (10) begin
                    step();
                    if (scan_enable !== 1'b0 || out_data !== hold ||
                        out_valid !== 1'b1) stall_bad++;
                end
                chk("stall_hold", stall_bad, 0);
                chk("stall_chain", (chain === snap), 1);
            end
            e = exp_q.pop_front();
            chk($sformatf("rd%0d", k), out_data, e);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        chk("done_pulse", done, 1);
        if (start_in_done) start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_clear", busy, 0);
        chk("done_cnt", done_cnt - d0, 1);
        chk("se_cnt", se_cnt - se0, 256);
        repeat (3) step();
        chk("no_extra_pass", {in_ready, busy}, 0);
        for (int k = 0; k < NB; k++) prev_buf[k] = wr_buf[k];
    endtask

    task automatic run8(input logic [7:0] wr, input logic [7:0] exp);
        int b0, t;
        b0 = busy8_cnt;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        chk("l8_in_ready", in_ready8, 1);
        in_data8  = wr;
        in_valid8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        t = 0;
        while (!out_valid8 && t < 40) begin step(); t++; end
        chk("l8_lat", t, 8);
        chk("l8_data", out_data8, exp);
        out_ready8 = 1'b1;
        step();
        out_ready8 = 1'b0;
        chk("l8_done", done8, 1);
        step();
        chk("l8_busy_clear", busy8, 0);
        chk("l8_busy_span", busy8_cnt - b0, 11);
    endtask

    initial begin
        int seen;
        for (int k = 0; k < NB; k++) prev_buf[k] = 8'h00;

        // Reset and idle behaviour
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("reset_outs",
            {in_ready, out_valid, scan_enable, scan_in, busy, done, out_data}, 0);
        chk("reset_outs8",
            {in_ready8, out_valid8, scan_enable8, busy8, done8, out_data8}, 0);
        in_valid = 1'b1;
        seen = 0;
        repeat (5) begin
            step();
            if (in_ready !== 1'b0 || scan_enable !== 1'b0) seen++;
        end
        in_valid = 1'b0;
        chk("idle_no_accept", seen, 0);

        // Pass A: ramp; readback is the zeroed chain
        for (int k = 0; k < NB; k++) wr_buf[k] = 8'(k);
        run_pass(0, -1, -1, 1'b0);

        // Pass B: 0xFF, stall at byte 5, start while busy at byte 10
        for (int k = 0; k < NB; k++) wr_buf[k] = 8'hFF;
        run_pass(0, 5, 10, 1'b0);

        // Pass C: alternating pattern with random input gaps
        for (int k = 0; k < NB; k++) wr_buf[k] = (k % 2 == 0) ? 8'hA5 : 8'h5A;
        run_pass(7, -1, -1, 1'b0);

        // Pass D: verify pass C, start pulsed in the DONE cycle
        for (int k = 0; k < NB; k++) wr_buf[k] = 8'(k * 7 + 3);
        run_pass(0, -1, -1, 1'b1);

        chk("no_ready_valid_overlap", overlap_cnt, 0);

        // Reset in the middle of a shift
        start = 1'b1;
        step();
        start = 1'b0;
        in_data  = 8'h55;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        chk("mid_shift_active", scan_enable, 1);
        rst = 1'b1;
        step();
        chk("mid_shift_reset",
            {in_ready, out_valid, scan_enable, scan_in, busy, done, out_data}, 0);
        rst = 1'b0;
        step();
        chk("post_reset_idle", {in_ready, scan_enable, busy}, 0);

        // 8-bit loopback configuration
        run8(8'hC3, 8'h00);
        run8(8'h3C, 8'hC3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
